// File: rtl/decode.sv
// RV32I decode stage: registers a decoded instruction bundle for execute,
// detects load-use hazards and honours stall/flush from downstream.
module decode #(
    parameter logic RESET_VALID = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic [31:0] pc1,
    input  logic        in_valid,
    input  logic        stall,
    input  logic        flush,
    output logic        hazard,
    output logic        d_valid,
    output logic [31:0] d_pc,
    output logic [4:0]  d_rs1,
    output logic [4:0]  d_rs2,
    output logic [4:0]  d_rd,
    output logic [31:0] d_imm,
    output logic [3:0]  d_alu_op,
    output logic [2:0]  d_funct3,
    output logic        d_src_a_pc,
    output logic        d_src_b_imm,
    output logic        d_reg_we,
    output logic        d_mem_re,
    output logic        d_mem_we,
    output logic        d_branch,
    output logic        d_jal,
    output logic        d_jalr,
    output logic        d_illegal,
    output logic [31:0] d_count
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic sub_en,
                                           input logic sra_en);
        case (f3)
            3'b000:  return sub_en ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return sra_en ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic signed [31:0] n_imm;
    logic [3:0]  n_alu;
    logic        n_a_pc, n_b_imm, n_we, n_re, n_mwe, n_br, n_jal, n_jalr, n_ill;
    logic        uses_rs1, uses_rs2;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b  = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u  = {ir[31:12], 12'h000};
    assign imm_j  = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};

    always_comb begin
        n_imm    = imm_i;
        n_alu    = ALU_ADD;
        n_a_pc   = 1'b0;
        n_b_imm  = 1'b1;
        n_we     = 1'b0;
        n_re     = 1'b0;
        n_mwe    = 1'b0;
        n_br     = 1'b0;
        n_jal    = 1'b0;
        n_jalr   = 1'b0;
        n_ill    = 1'b0;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        // The full 7-bit opcode includes ir[1:0], so compressed encodings fall to default.
        case (opcode)
            OPC_LUI:    begin n_imm = imm_u; n_alu = ALU_PASSB; n_we = 1'b1; uses_rs1 = 1'b0; end
            OPC_AUIPC:  begin n_imm = imm_u; n_a_pc = 1'b1; n_we = 1'b1; uses_rs1 = 1'b0; end
            OPC_JAL:    begin
                n_imm = imm_j; n_a_pc = 1'b1; n_we = 1'b1; n_jal = 1'b1; uses_rs1 = 1'b0;
            end
            OPC_JALR:   begin n_we = 1'b1; n_jalr = 1'b1; end
            OPC_BRANCH: begin
                n_imm = imm_b; n_alu = ALU_SUB; n_b_imm = 1'b0; n_br = 1'b1; uses_rs2 = 1'b1;
            end
            OPC_LOAD:   begin n_we = 1'b1; n_re = 1'b1; end
            OPC_STORE:  begin n_imm = imm_s; n_mwe = 1'b1; uses_rs2 = 1'b1; end
            OPC_OPIMM:  begin n_alu = alu_sel(ir[14:12], 1'b0, ir[30]); n_we = 1'b1; end
            OPC_OP:     begin
                n_alu = alu_sel(ir[14:12], ir[30], ir[30]); n_b_imm = 1'b0; n_we = 1'b1;
                uses_rs2 = 1'b1;
            end
            default:    n_ill = 1'b1;
        endcase
        if (rd == 5'd0) n_we = 1'b0;
    end

    assign hazard = d_valid & d_mem_re & (d_rd != 5'd0) & in_valid &
                    ((uses_rs1 & (rs1 == d_rd)) | (uses_rs2 & (rs2 == d_rd)));

    always_ff @(posedge clk) begin
        if (!reset) begin
            d_valid     <= RESET_VALID;
            d_pc        <= '0;
            d_rs1       <= '0;
            d_rs2       <= '0;
            d_rd        <= '0;
            d_imm       <= '0;
            d_alu_op    <= '0;
            d_funct3    <= '0;
            d_src_a_pc  <= 1'b0;
            d_src_b_imm <= 1'b0;
            d_reg_we    <= 1'b0;
            d_mem_re    <= 1'b0;
            d_mem_we    <= 1'b0;
            d_branch    <= 1'b0;
            d_jal       <= 1'b0;
            d_jalr      <= 1'b0;
            d_illegal   <= 1'b0;
            d_count     <= '0;
        end else if (flush || (!stall && hazard)) begin
            // Kill or bubble: clearing the flags also keeps a stale load from re-triggering hazard.
            d_valid     <= 1'b0;
            d_src_a_pc  <= 1'b0;
            d_src_b_imm <= 1'b0;
            d_reg_we    <= 1'b0;
            d_mem_re    <= 1'b0;
            d_mem_we    <= 1'b0;
            d_branch    <= 1'b0;
            d_jal       <= 1'b0;
            d_jalr      <= 1'b0;
            d_illegal   <= 1'b0;
        end else if (!stall) begin
            d_valid     <= in_valid;
            d_pc        <= pc1;
            d_rs1       <= rs1;
            d_rs2       <= rs2;
            d_rd        <= rd;
            d_imm       <= n_imm;
            d_alu_op    <= n_alu;
            d_funct3    <= ir[14:12];
            d_src_a_pc  <= n_a_pc;
            d_src_b_imm <= n_b_imm;
            d_reg_we    <= n_we;
            d_mem_re    <= n_re;
            d_mem_we    <= n_mwe;
            d_branch    <= n_br;
            d_jal       <= n_jal;
            d_jalr      <= n_jalr;
            d_illegal   <= n_ill;
            if (in_valid) d_count <= d_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_decode.sv
// Bench for the decode stage: directed vector table, hand-written
// multi-cycle sequences, then a randomized run against a reference model.
module tb_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ir = '0;
    logic [31:0] pc1 = '0;
    logic        in_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        hazard, d_valid;
    logic [31:0] d_pc, d_imm, d_count;
    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic [3:0]  d_alu_op;
    logic [2:0]  d_funct3;
    logic        d_src_a_pc, d_src_b_imm, d_reg_we, d_mem_re, d_mem_we;
    logic        d_branch, d_jal, d_jalr, d_illegal;

    int vectors = 0;
    int miscompares = 0;

    decode #(.RESET_VALID(1'b0)) dut (
        .clk(clk), .reset(reset), .ir(ir), .pc1(pc1), .in_valid(in_valid),
        .stall(stall), .flush(flush), .hazard(hazard), .d_valid(d_valid),
        .d_pc(d_pc), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd), .d_imm(d_imm),
        .d_alu_op(d_alu_op), .d_funct3(d_funct3), .d_src_a_pc(d_src_a_pc),
        .d_src_b_imm(d_src_b_imm), .d_reg_we(d_reg_we), .d_mem_re(d_mem_re),
        .d_mem_we(d_mem_we), .d_branch(d_branch), .d_jal(d_jal), .d_jalr(d_jalr),
        .d_illegal(d_illegal), .d_count(d_count)
    );

    always #5 clk = ~clk;

    // flags order: {src_a_pc, src_b_imm, reg_we, mem_re, mem_we, branch, jal, jalr, illegal}
    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic        full;
        logic        chk_imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [8:0]  flags;
    } vec_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic [8:0]  flags;
        logic        imm_def;
        logic        alu_def;
    } bundle_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [8:0] dut_flags();
        return {d_src_a_pc, d_src_b_imm, d_reg_we, d_mem_re, d_mem_we,
                d_branch, d_jal, d_jalr, d_illegal};
    endfunction

    // Reference ALU choice for register/immediate arithmetic, by funct3 name.
    function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic is_op,
                                           input logic b30);
        logic [3:0] by_f3 [8];
        by_f3 = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
        if (f3 == 3'd0 && is_op && b30) return 4'd1;
        if (f3 == 3'd5 && b30) return 4'd7;
        return by_f3[f3];
    endfunction

    function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        bundle_t b;
        logic signed [11:0] i12;
        logic signed [11:0] s12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        b = '0;
        b.valid = 1'b1; b.pc = pc; b.rd = w[11:7]; b.rs1 = w[19:15]; b.rs2 = w[24:20];
        b.f3 = w[14:12]; b.imm_def = 1'b1; b.alu_def = 1'b1;
        i12 = w[31:20];
        s12 = {w[31:25], w[11:7]};
        b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        case (w[6:0])
            7'h37: begin b.imm = w & 32'hFFFFF000; b.alu = 4'd10; b.flags = 9'b011000000; end
            7'h17: begin b.imm = w & 32'hFFFFF000; b.alu = 4'd0; b.flags = 9'b111000000; end
            7'h6F: begin b.imm = 32'(j21); b.alu = 4'd0; b.flags = 9'b111000100; end
            7'h67: begin b.imm = 32'(i12); b.alu = 4'd0; b.flags = 9'b011000010; end
            7'h63: begin b.imm = 32'(b13); b.alu = 4'd1; b.flags = 9'b000001000; end
            7'h03: begin b.imm = 32'(i12); b.alu = 4'd0; b.flags = 9'b011100000; end
            7'h23: begin b.imm = 32'(s12); b.alu = 4'd0; b.flags = 9'b010010000; end
            7'h13: begin b.imm = 32'(i12); b.alu = ref_alu(w[14:12], 1'b0, w[30]);
                         b.flags = 9'b011000000; end
            7'h33: begin b.imm_def = 1'b0; b.alu = ref_alu(w[14:12], 1'b1, w[30]);
                         b.flags = 9'b001000000; end
            default: begin b.imm_def = 1'b0; b.alu_def = 1'b0; b.flags = 9'b010000001; end
        endcase
        if (b.rd == 5'd0) b.flags[6] = 1'b0;
        return b;
    endfunction

    function automatic logic ref_hazard(input bundle_t m, input logic [31:0] w, input logic v);
        logic u1, u2;
        u1 = !(w[6:0] inside {7'h37, 7'h17, 7'h6F});
        u2 = (w[6:0] inside {7'h33, 7'h23, 7'h63});
        return m.valid && m.flags[5] && m.rd != 5'd0 && v &&
               ((u1 && w[19:15] == m.rd) || (u2 && w[24:20] == m.rd));
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 11);
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        case (k)
            0: w[6:0] = 7'h37;  1: w[6:0] = 7'h17;  2: w[6:0] = 7'h6F;
            3: w[6:0] = 7'h67;  4: w[6:0] = 7'h63;  5: w[6:0] = 7'h23;
            6: w[6:0] = 7'h13;  7: w[6:0] = 7'h33;  8: w[1:0] = 2'b00;
            default: w[6:0] = 7'h03;
        endcase
        return w;
    endfunction

    task automatic compare_model(input bundle_t m, input logic [31:0] mcount);
        chk("rnd_valid", 32'(d_valid), 32'(m.valid));
        chk("rnd_count", d_count, mcount);
        if (m.valid) begin
            chk("rnd_pc", d_pc, m.pc);
            chk("rnd_rs1", 32'(d_rs1), 32'(m.rs1));
            chk("rnd_rs2", 32'(d_rs2), 32'(m.rs2));
            chk("rnd_rd", 32'(d_rd), 32'(m.rd));
            chk("rnd_funct3", 32'(d_funct3), 32'(m.f3));
            chk("rnd_flags", 32'(dut_flags()), 32'(m.flags));
            if (m.imm_def) chk("rnd_imm", d_imm, m.imm);
            if (m.alu_def) chk("rnd_alu", 32'(d_alu_op), 32'(m.alu));
        end
    endtask

    vec_t    tbl [12];
    bundle_t m;
    logic [31:0] mcount;
    logic [31:0] exp_count;
    logic        exp_haz;
    logic        hold;

    initial begin
        tbl[0]  = '{32'h00500093, 32'h200, 1'b1, 1'b1, 5'd1,  5'd0,  5'd5,  32'd5,        4'd0,  9'b011000000};
        tbl[1]  = '{32'h0030A423, 32'h204, 1'b1, 1'b1, 5'd8,  5'd1,  5'd3,  32'd8,        4'd0,  9'b010010000};
        tbl[2]  = '{32'h123452B7, 32'h208, 1'b1, 1'b1, 5'd5,  5'd8,  5'd3,  32'h12345000, 4'd10, 9'b011000000};
        tbl[3]  = '{32'hFFFFFFFF, 32'h20C, 1'b0, 1'b0, 5'd31, 5'd31, 5'd31, 32'd0,        4'd0,  9'b000000001};
        tbl[4]  = '{32'h00500013, 32'h210, 1'b1, 1'b1, 5'd0,  5'd0,  5'd5,  32'd5,        4'd0,  9'b010000000};
        tbl[5]  = '{32'hFE208EE3, 32'h214, 1'b1, 1'b1, 5'd29, 5'd1,  5'd2,  32'hFFFFFFFC, 4'd1,  9'b000001000};
        tbl[6]  = '{32'h008000EF, 32'h218, 1'b1, 1'b1, 5'd1,  5'd0,  5'd8,  32'd8,        4'd0,  9'b111000100};
        tbl[7]  = '{32'h402081B3, 32'h21C, 1'b1, 1'b0, 5'd3,  5'd1,  5'd2,  32'd0,        4'd1,  9'b001000000};
        tbl[8]  = '{32'h4030D213, 32'h220, 1'b1, 1'b1, 5'd4,  5'd1,  5'd3,  32'h403,      4'd7,  9'b011000000};
        tbl[9]  = '{32'h00001297, 32'h224, 1'b1, 1'b1, 5'd5,  5'd0,  5'd0,  32'h1000,     4'd0,  9'b111000000};
        tbl[10] = '{32'h0000A103, 32'h228, 1'b1, 1'b1, 5'd2,  5'd1,  5'd0,  32'd0,        4'd0,  9'b011100000};
        tbl[11] = '{32'h00008067, 32'h22C, 1'b1, 1'b1, 5'd0,  5'd1,  5'd0,  32'd0,        4'd0,  9'b010000010};

        // Reset held with a live instruction presented
        @(negedge clk);
        reset = 1'b0; ir = 32'h00500093; pc1 = 32'h100; in_valid = 1'b1;
        repeat (3) step();
        chk("reset_valid", 32'(d_valid), 32'd0);
        chk("reset_count", d_count, 32'd0);
        chk("reset_flags", 32'(dut_flags()), 32'd0);
        chk("reset_pc", d_pc, 32'd0);
        chk("reset_imm", d_imm, 32'd0);
        chk("reset_rd", 32'(d_rd), 32'd0);
        chk("reset_hazard", 32'(hazard), 32'd0);

        reset = 1'b1; in_valid = 1'b0;
        step();
        chk("post_reset_valid", 32'(d_valid), 32'd0);
        chk("post_reset_count", d_count, 32'd0);

        // addi x1,x0,5
        in_valid = 1'b1; ir = 32'h00500093; pc1 = 32'h100;
        step();
        chk("addi_valid", 32'(d_valid), 32'd1);
        chk("addi_rd", 32'(d_rd), 32'd1);
        chk("addi_rs1", 32'(d_rs1), 32'd0);
        chk("addi_imm", d_imm, 32'd5);
        chk("addi_alu", 32'(d_alu_op), 32'd0);
        chk("addi_b_imm", 32'(d_src_b_imm), 32'd1);
        chk("addi_we", 32'(d_reg_we), 32'd1);
        chk("addi_pc", d_pc, 32'h100);
        chk("addi_count", d_count, 32'd1);
        exp_count = 32'd1;

        for (int i = 0; i < 12; i++) begin
            ir = tbl[i].ir; pc1 = tbl[i].pc; in_valid = 1'b1;
            #1 chk("tbl_hazard", 32'(hazard), 32'd0);
            step();
            exp_count++;
            chk("tbl_valid", 32'(d_valid), 32'd1);
            chk("tbl_pc", d_pc, tbl[i].pc);
            chk("tbl_rd", 32'(d_rd), 32'(tbl[i].rd));
            chk("tbl_rs1", 32'(d_rs1), 32'(tbl[i].rs1));
            chk("tbl_rs2", 32'(d_rs2), 32'(tbl[i].rs2));
            chk("tbl_funct3", 32'(d_funct3), 32'(tbl[i].ir[14:12]));
            chk("tbl_count", d_count, exp_count);
            if (tbl[i].chk_imm) chk("tbl_imm", d_imm, tbl[i].imm);
            if (tbl[i].full) begin
                chk("tbl_alu", 32'(d_alu_op), 32'(tbl[i].alu));
                chk("tbl_flags", 32'(dut_flags()), 32'(tbl[i].flags));
            end else begin
                chk("tbl_enables", 32'(dut_flags() & 9'h07F), 32'(tbl[i].flags & 9'h07F));
            end
        end

        // Load-use: lw x2,0(x1) followed by add x3,x2,x1, first under stall
        ir = 32'h0000A103; pc1 = 32'h300;
        step();
        exp_count++;
        ir = 32'h001101B3; pc1 = 32'h304; stall = 1'b1;
        #1 chk("lu_hazard_stalled", 32'(hazard), 32'd1);
        step();
        chk("lu_stall_held_re", 32'(d_mem_re), 32'd1);
        chk("lu_stall_held_valid", 32'(d_valid), 32'd1);
        chk("lu_hazard_still", 32'(hazard), 32'd1);
        stall = 1'b0;
        step();
        chk("lu_bubble_valid", 32'(d_valid), 32'd0);
        chk("lu_bubble_count", d_count, exp_count);
        chk("lu_hazard_clear", 32'(hazard), 32'd0);
        step();
        exp_count++;
        chk("lu_add_valid", 32'(d_valid), 32'd1);
        chk("lu_add_rs1", 32'(d_rs1), 32'd2);
        chk("lu_add_rs2", 32'(d_rs2), 32'd1);
        chk("lu_add_alu", 32'(d_alu_op), 32'd0);
        chk("lu_add_b_imm", 32'(d_src_b_imm), 32'd0);
        chk("lu_add_count", d_count, exp_count);

        // Stall holds a store, then stall+flush kills it
        ir = 32'h0030A423; pc1 = 32'h400;
        step();
        exp_count++;
        stall = 1'b1; ir = 32'h123452B7; pc1 = 32'h404;
        repeat (2) step();
        chk("stall_imm", d_imm, 32'd8);
        chk("stall_mem_we", 32'(d_mem_we), 32'd1);
        chk("stall_pc", d_pc, 32'h400);
        chk("stall_count", d_count, exp_count);
        flush = 1'b1;
        step();
        chk("flush_valid", 32'(d_valid), 32'd0);
        chk("flush_mem_we", 32'(d_mem_we), 32'd0);
        chk("flush_count", d_count, exp_count);
        flush = 1'b0; reset = 1'b0;
        step();
        chk("reset_in_stall_count", d_count, 32'd0);
        chk("reset_in_stall_valid", 32'(d_valid), 32'd0);
        reset = 1'b1; stall = 1'b0;

        // Counter wrap: preload the count just below the wrap point
        ir = 32'h00500093; pc1 = 32'h500; in_valid = 1'b1;
        force dut.d_count = 32'hFFFFFFFF;
        #1 release dut.d_count;
        step();
        chk("wrap_count", d_count, 32'd0);
        chk("wrap_valid", 32'(d_valid), 32'd1);

        // Randomized run against the reference model
        reset = 1'b0; in_valid = 1'b0;
        step();
        m = '0; mcount = '0; hold = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!hold) begin
                ir = rand_ir();
                pc1 = $urandom & 32'hFFFFFFFC;
                in_valid = ($urandom_range(0, 9) != 0);
            end
            stall = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 99) != 0);
            exp_haz = ref_hazard(m, ir, in_valid);
            #1 chk("rnd_hazard", 32'(hazard), 32'(exp_haz));
            if (!reset) begin
                m = '0; mcount = '0;
            end else if (flush) begin
                m.valid = 1'b0; m.flags = '0;
            end else if (!stall) begin
                if (exp_haz) begin
                    m.valid = 1'b0; m.flags = '0;
                end else begin
                    m = ref_decode(ir, pc1);
                    m.valid = in_valid;
                    if (in_valid) mcount++;
                end
            end
            hold = reset && !flush && (stall || exp_haz);
            step();
            compare_model(m, mcount);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/decode.md
# decode

Second pipeline stage of the RV32I core. It consumes the instruction word and its PC from the fetch stage and registers a fully decoded instruction bundle for execute: operand indices, sign-extended immediate, ALU op, memory and control-flow flags. It also performs load-use hazard detection, and honours downstream stall and flush requests. It owns a free-running count of issued instructions.

## Interface
- `RESET_VALID`, default 0: reset value of `d_valid`; must stay 0.
- `clk`, input, 1: sole clock; everything updates on its rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `ir`, input, 32: instruction word from fetch.
- `pc1`, input, 32: PC of `ir`.
- `in_valid`, input, 1: `ir`/`pc1` hold a real instruction.
- `stall`, input, 1: execute cannot accept; hold all outputs.
- `flush`, input, 1: branch/jump redirect; kill the in-flight decode.
- `hazard`, output, 1: combinational load-use hazard; upstream must hold `next_pc`.
- `d_valid`, output, 1: decoded bundle is valid.
- `d_pc`, output, 32: PC of the bundle.
- `d_rs1`, `d_rs2`, `d_rd`, output, 5 each: register indices.
- `d_imm`, output, 32: sign-extended immediate.
- `d_alu_op`, output, 4: ALU opcode.
- `d_funct3`, output, 3: raw funct3.
- `d_src_a_pc`, output, 1: ALU operand A is `d_pc`.
- `d_src_b_imm`, output, 1: ALU operand B is `d_imm`.
- `d_reg_we`, output, 1: register write enable.
- `d_mem_re`, `d_mem_we`, output, 1 each: load / store.
- `d_branch`, `d_jal`, `d_jalr`, output, 1 each: control-flow class.
- `d_illegal`, output, 1: unrecognised encoding.
- `d_count`, output, 32: number of bundles issued with `d_valid`=1.

## Operation
- **Update priority each edge:** reset > flush > stall > hazard > normal.
- **Reset** (`reset`=0): every output register is cleared to 0, including `d_count`.
- **Flush:** `d_valid`←0 and all flags←0. `d_count` is unchanged. Flush overrides a simultaneous stall.
- **Stall:** all outputs hold their current values, including `d_count`.
- **Hazard:** `hazard` = `d_valid` & `d_mem_re` & (`d_rd`≠0) & `in_valid` & ((incoming instruction uses rs1 & rs1==`d_rd`) | (uses rs2 & rs2==`d_rd`)).
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used only by OP, STORE and BRANCH.
  - On hazard, a bubble is inserted: `d_valid`←0 and the other fields are don't-care.
  - The upstream stage re-presents the same `ir`/`pc1` next cycle.
- **Normal:** `d_valid`←`in_valid` and the fields are decoded from `ir`. `d_count`←`d_count`+1 when `in_valid`, wrapping 0xFFFFFFFF→0.
- **Immediates:**
  - I-type (OP-IMM, LOAD, JALR): ir[31:20], sign-extended.
  - S-type: {ir[31:25], ir[11:7]}.
  - B-type: {ir[31], ir[7], ir[30:25], ir[11:8], 0}.
  - U-type: {ir[31:12], 12'h0}.
  - J-type: {ir[31], ir[19:12], ir[20], ir[30:21], 0}.
  - All are sign-extended from their top bit.
- **ALU op encoding:** ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10.
  - OP selects SUB/SRA via ir[30].
  - OP-IMM selects SRAI via ir[30] only when funct3=101.
  - LOAD, STORE, AUIPC, JAL and JALR use ADD.
  - LUI uses PASSB.
  - BRANCH uses SUB, and execute compares using `d_funct3`.
- **Operand selects:** `d_src_a_pc`=1 for AUIPC and JAL. `d_src_b_imm`=1 for every opcode except OP and BRANCH.
- **`d_reg_we`:** 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL and JALR, forced to 0 when rd=0.
- **Illegal encodings:** any unlisted opcode, or ir[1:0]≠11, sets `d_illegal`=1 with `d_reg_we`, `d_mem_re`, `d_mem_we`, `d_branch`, `d_jal` and `d_jalr` all 0. `d_valid` still follows `in_valid`.

## Timing
- Latency is 1 cycle: `ir` sampled at edge N appears on the `d_*` outputs after edge N.
- `hazard` is combinational from the current `d_*` outputs and `ir`. It must settle in the same cycle so fetch can hold `next_pc`.
- Fetch also has 1-cycle latency, so `in_valid` is 0 in the first cycle after reset is released.
- When `stall` and `hazard` are both asserted, stall wins and the bundle is held. `hazard` stays asserted, because the same load is still in decode's output.
- Reset asserted mid-stall or mid-hazard clears all outputs on that edge.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with `ir`=0x00500093 and `in_valid`=1 → all outputs 0 and `d_count`=0.
- **ADDI:** `ir`=0x00500093 (addi x1,x0,5), `pc1`=0x100 → next cycle `d_valid`=1, `d_rd`=1, `d_rs1`=0, `d_imm`=5, `d_alu_op`=0, `d_src_b_imm`=1, `d_reg_we`=1, `d_pc`=0x100, `d_count`=1.
- **Load-use:** issue 0x0000A103 (lw x2,0(x1)), then present 0x001101B3 (add x3,x2,x1) → `hazard`=1 that cycle and `d_valid`=0 next. Re-presenting the add → `d_valid`=1, `d_rs1`=2, `d_rs2`=1, `d_alu_op`=0, `d_src_b_imm`=0.
- **Store and LUI:** `ir`=0x0030A423 (sw x3,8(x1)) → `d_imm`=8, `d_mem_we`=1, `d_reg_we`=0. `ir`=0x123452B7 → `d_imm`=0x12345000, `d_alu_op`=10.
- **Stall then flush:** assert `stall` for 2 cycles → outputs frozen. Assert `stall` and `flush` together → `d_valid`=0 and `d_count` unchanged.
- **Illegal and x0 write:** `ir`=0xFFFFFFFF → `d_illegal`=1 with all enables 0. `ir`=0x00500013 (addi x0,x0,5) → `d_reg_we`=0. Drive `d_count` past 0xFFFFFFFF → wraps to 0.
